// File: rtl/icache_dm_pkg.sv
// Shared definitions for the direct-mapped instruction cache: FSM state
// encodings, default geometry and the instruction word width.
package icache_dm_pkg;

  localparam int IC_INDEX_W = 8;
  localparam int IC_ADDR_W  = 18;
  localparam int IC_WORD_W  = 32;

  typedef enum logic [1:0] {
    IC_IDLE = 2'd0,
    IC_MISS = 2'd1,
    IC_RESP = 2'd2
  } ic_state_e;

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the direct-mapped instruction cache with a
// combinational hit lookup and a single write port.
module icache_array
  import icache_dm_pkg::*;
#(
  parameter int INDEX_W = IC_INDEX_W,
  parameter int TAG_W   = IC_ADDR_W - IC_INDEX_W - 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [INDEX_W-1:0]   i_rd_index,
  input  logic [TAG_W-1:0]     i_rd_tag,
  output logic                 o_hit,
  output logic [IC_WORD_W-1:0] o_rd_data,
  input  logic                 i_we,
  input  logic [INDEX_W-1:0]   i_wr_index,
  input  logic [TAG_W-1:0]     i_wr_tag,
  input  logic [IC_WORD_W-1:0] i_wr_data
);

  localparam int LINES = 1 << INDEX_W;

  logic [LINES-1:0]     r_valid;
  logic [TAG_W-1:0]     r_tag  [LINES];
  logic [IC_WORD_W-1:0] r_data [LINES];

  // Valid bits are the only storage that needs a reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
    end else if (i_we) begin
      r_valid[i_wr_index] <= 1'b1;
    end
  end

  // Tag and data arrays: a fill overwrites the line unconditionally.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_tag[i_wr_index]  <= i_wr_tag;
      r_data[i_wr_index] <= i_wr_data;
    end
  end

  assign o_hit     = r_valid[i_rd_index] && (r_tag[i_rd_index] == i_rd_tag);
  assign o_rd_data = r_data[i_rd_index];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache (fetcher <-> mem_ctrl).
// Optional hit/miss counters are enabled with the ICACHE_STATS_EN macro.
module icache_dm
  import icache_dm_pkg::*;
#(
  parameter int INDEX_W = IC_INDEX_W,
  parameter int ADDR_W  = IC_ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 clear,
  input  logic                 from_if_ready,
  input  logic [31:0]          from_if_addr,
  output logic                 to_if_ok,
  output logic [IC_WORD_W-1:0] to_if_ins,
  output logic                 to_mctr_ready,
  output logic [31:0]          to_mctr_addr,
  input  logic                 from_mctr_ok,
  input  logic [IC_WORD_W-1:0] from_mctr_data
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]          hit_cnt,
  output logic [31:0]          miss_cnt
`endif
);

  localparam int TAG_W = ADDR_W - INDEX_W - 2;

  ic_state_e            r_state;
  logic [INDEX_W-1:0]   r_miss_index;
  logic [TAG_W-1:0]     r_miss_tag;

  logic [INDEX_W-1:0]   w_req_index;
  logic [TAG_W-1:0]     w_req_tag;
  logic                 w_hit;
  logic [IC_WORD_W-1:0] w_hit_data;
  logic                 w_fill;
  logic                 w_unused_addr;

  assign w_req_index   = from_if_addr[INDEX_W+1:2];
  assign w_req_tag     = from_if_addr[ADDR_W-1:INDEX_W+2];
  assign w_unused_addr = ^from_if_addr[1:0];
  // A fill landing in the same cycle as clear is dropped, not written.
  assign w_fill        = rdy && !clear && (r_state == IC_MISS) && from_mctr_ok;

  icache_array #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .i_rd_index (w_req_index),
    .i_rd_tag   (w_req_tag),
    .o_hit      (w_hit),
    .o_rd_data  (w_hit_data),
    .i_we       (w_fill),
    .i_wr_index (r_miss_index),
    .i_wr_tag   (r_miss_tag),
    .i_wr_data  (from_mctr_data)
  );

  // Request FSM with registered fetcher and mem_ctrl outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IC_IDLE;
      r_miss_index  <= '0;
      r_miss_tag    <= '0;
      to_if_ok      <= 1'b0;
      to_if_ins     <= 32'd0;
      to_mctr_ready <= 1'b0;
      to_mctr_addr  <= 32'd0;
    end else if (rdy) begin
      if (clear) begin
        r_state       <= IC_IDLE;
        to_if_ok      <= 1'b0;
        to_mctr_ready <= 1'b0;
      end else begin
        case (r_state)
          IC_IDLE: begin
            to_if_ok <= 1'b0;
            if (from_if_ready) begin
              if (w_hit) begin
                to_if_ok  <= 1'b1;
                to_if_ins <= w_hit_data;
              end else begin
                r_miss_index  <= w_req_index;
                r_miss_tag    <= w_req_tag;
                to_mctr_ready <= 1'b1;
                to_mctr_addr  <= {from_if_addr[31:2], 2'b00};
                r_state       <= IC_MISS;
              end
            end
          end
          IC_MISS: begin
            if (from_mctr_ok) begin
              to_mctr_ready <= 1'b0;
              to_if_ok      <= 1'b1;
              to_if_ins     <= from_mctr_data;
              r_state       <= IC_RESP;
            end
          end
          IC_RESP: begin
            to_if_ok <= 1'b0;
            r_state  <= IC_IDLE;
          end
          default: begin
            to_if_ok      <= 1'b0;
            to_mctr_ready <= 1'b0;
            r_state       <= IC_IDLE;
          end
        endcase
      end
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  // Counters advance only on requests actually accepted in IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hit_cnt  <= 32'd0;
      r_miss_cnt <= 32'd0;
    end else if (rdy && !clear && (r_state == IC_IDLE) && from_if_ready) begin
      if (w_hit) begin
        r_hit_cnt <= r_hit_cnt + 32'd1;
      end else begin
        r_miss_cnt <= r_miss_cnt + 32'd1;
      end
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm: directed scenarios with literal
// expectations, then randomized traffic against a behavioural cache model.
module tb_icache_dm;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        clear;
  logic        from_if_ready;
  logic [31:0] from_if_addr;
  logic        to_if_ok;
  logic [31:0] to_if_ins;
  logic        to_mctr_ready;
  logic [31:0] to_mctr_addr;
  logic        from_mctr_ok;
  logic [31:0] from_mctr_data;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  icache_dm dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .clear          (clear),
    .from_if_ready  (from_if_ready),
    .from_if_addr   (from_if_addr),
    .to_if_ok       (to_if_ok),
    .to_if_ins      (to_if_ins),
    .to_mctr_ready  (to_mctr_ready),
    .to_mctr_addr   (to_mctr_addr),
    .from_mctr_ok   (from_mctr_ok),
    .from_mctr_data (from_mctr_data)
`ifdef ICACHE_STATS_EN
    ,
    .hit_cnt        (hit_cnt),
    .miss_cnt       (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural model: a line holds the word address it caches plus the word.
  logic        m_lv  [256];
  logic [15:0] m_lwa [256];
  logic [31:0] m_ld  [256];
  logic        m_ok, m_mreq;
  logic [31:0] m_ins, m_maddr;
  logic [15:0] m_fill_wa;
  int          m_phase;  // 0 waiting for request, 1 waiting for fill, 2 answering fill
  logic [31:0] m_hits, m_misses;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ok <= 1'b0; m_mreq <= 1'b0; m_ins <= 32'd0; m_maddr <= 32'd0;
      m_phase <= 0; m_hits <= 32'd0; m_misses <= 32'd0; m_fill_wa <= 16'd0;
      for (int i = 0; i < 256; i++) m_lv[i] <= 1'b0;
    end else if (rdy) begin
      if (clear) begin
        m_ok <= 1'b0; m_mreq <= 1'b0; m_phase <= 0;
      end else if (m_phase == 0) begin
        m_ok <= 1'b0;
        if (from_if_ready) begin
          if (m_lv[from_if_addr[9:2]] && m_lwa[from_if_addr[9:2]] == from_if_addr[17:2]) begin
            m_ok <= 1'b1; m_ins <= m_ld[from_if_addr[9:2]]; m_hits <= m_hits + 32'd1;
          end else begin
            m_mreq <= 1'b1; m_maddr <= from_if_addr & 32'hFFFF_FFFC;
            m_fill_wa <= from_if_addr[17:2]; m_phase <= 1; m_misses <= m_misses + 32'd1;
          end
        end
      end else if (m_phase == 1) begin
        if (from_mctr_ok) begin
          m_lv[m_fill_wa[7:0]] <= 1'b1; m_lwa[m_fill_wa[7:0]] <= m_fill_wa;
          m_ld[m_fill_wa[7:0]] <= from_mctr_data;
          m_ok <= 1'b1; m_ins <= from_mctr_data; m_mreq <= 1'b0; m_phase <= 2;
        end
      end else begin
        m_ok <= 1'b0; m_phase <= 0;
      end
    end
  end

  int n_checks = 0;
  int n_err    = 0;
  logic [31:0] mem [65536];
  logic last_rdy, last_clear, mem_busy;
  int   mem_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("ok", {31'd0, to_if_ok}, {31'd0, m_ok});
    chk("mreq", {31'd0, to_mctr_ready}, {31'd0, m_mreq});
    if (m_ok || !rst) chk("ins", to_if_ins, m_ins);
    if (m_mreq || !rst) chk("maddr", to_mctr_addr, m_maddr);
`ifdef ICACHE_STATS_EN
    chk("hit_cnt", hit_cnt, m_hits);
    chk("miss_cnt", miss_cnt, m_misses);
`endif
  endtask

  task automatic tick();
    @(negedge clk);
    compare();
  endtask

  task automatic req(input logic [31:0] a);
    from_if_ready = 1'b1;
    from_if_addr  = a;
  endtask

  task automatic do_miss(input string nm, input logic [31:0] a, input int lat, input logic [31:0] d);
    req(a);
    tick();
    chk({nm, "_mreq"}, {31'd0, to_mctr_ready}, 32'd1);
    chk({nm, "_maddr"}, to_mctr_addr, a & 32'hFFFF_FFFC);
    repeat (lat) begin
      tick();
      chk({nm, "_hold"}, to_mctr_addr, a & 32'hFFFF_FFFC);
      chk({nm, "_noresp"}, {31'd0, to_if_ok}, 32'd0);
    end
    from_mctr_ok = 1'b1; from_mctr_data = d;
    tick();
    chk({nm, "_ok"}, {31'd0, to_if_ok}, 32'd1);
    chk({nm, "_ins"}, to_if_ins, d);
    chk({nm, "_mdrop"}, {31'd0, to_mctr_ready}, 32'd0);
    from_mctr_ok = 1'b0; from_if_ready = 1'b0;
    tick();
    chk({nm, "_once"}, {31'd0, to_if_ok}, 32'd0);
  endtask

  task automatic do_hit(input string nm, input logic [31:0] a, input logic [31:0] d);
    req(a);
    tick();
    chk({nm, "_ok"}, {31'd0, to_if_ok}, 32'd1);
    chk({nm, "_ins"}, to_if_ins, d);
    chk({nm, "_nomreq"}, {31'd0, to_mctr_ready}, 32'd0);
    from_if_ready = 1'b0;
    tick();
    chk({nm, "_once"}, {31'd0, to_if_ok}, 32'd0);
  endtask

  initial begin
    logic [31:0] ra;
    rst = 1'b0; rdy = 1'b1; clear = 1'b0; from_if_ready = 1'b0; from_if_addr = 32'd0;
    from_mctr_ok = 1'b0; from_mctr_data = 32'd0;
    for (int i = 0; i < 65536; i++) mem[i] = 32'h9E37_79B9 * i + 32'h1234_5678;
    tick(); tick();
    chk("rst_ok", {31'd0, to_if_ok}, 32'd0);
    chk("rst_ins", to_if_ins, 32'd0);
    chk("rst_mreq", {31'd0, to_mctr_ready}, 32'd0);
    chk("rst_maddr", to_mctr_addr, 32'd0);
    rst = 1'b1;
    tick();

    // Cold miss then hit on the filled line.
    do_miss("cold", 32'h0000_0004, 2, 32'h00A0_0093);
    chk("model_cold_ins", m_ins, 32'h00A0_0093);
`ifdef ICACHE_STATS_EN
    chk("cold_miss_cnt", miss_cnt, 32'd1);
`endif
    do_hit("hit", 32'h0000_0004, 32'h00A0_0093);
`ifdef ICACHE_STATS_EN
    chk("hit_hit_cnt", hit_cnt, 32'd1);
`endif

    // Same index, different tag: evict, then refetch the original line.
    do_miss("evict", 32'h0000_0404, 1, 32'h1111_1111);
    do_miss("refetch", 32'h0000_0004, 1, 32'h2222_2222);
    do_hit("rehit", 32'h0000_0004, 32'h2222_2222);

    // Clear mid-miss: late fill must be ignored and the line stays invalid.
    req(32'h0000_0100); tick(); tick();
    clear = 1'b1; from_if_ready = 1'b0; tick();
    chk("clr_ok", {31'd0, to_if_ok}, 32'd0);
    chk("clr_mreq", {31'd0, to_mctr_ready}, 32'd0);
    clear = 1'b0; from_mctr_ok = 1'b1; from_mctr_data = 32'hDEAD_BEEF; tick();
    chk("clr_late_ok", {31'd0, to_if_ok}, 32'd0);
    from_mctr_ok = 1'b0;
    do_miss("clr_remiss", 32'h0000_0100, 0, 32'h5555_0100);

    // Clear in the very cycle the fill arrives: fill discarded.
    req(32'h0000_0200); tick();
    clear = 1'b1; from_mctr_ok = 1'b1; from_mctr_data = 32'h4444_4444; from_if_ready = 1'b0; tick();
    chk("clrfill_ok", {31'd0, to_if_ok}, 32'd0);
    clear = 1'b0; from_mctr_ok = 1'b0;
    do_miss("clrfill_remiss", 32'h0000_0200, 0, 32'h4444_0200);

    // Clear together with a request that would hit: request dropped.
    req(32'h0000_0004); clear = 1'b1; tick();
    chk("clrreq_ok", {31'd0, to_if_ok}, 32'd0);
    clear = 1'b0; from_if_ready = 1'b0; tick();

    // rdy stall in MISS (fill held, not consumed) and in RESP.
    req(32'h0000_0300); tick();
    rdy = 1'b0; from_mctr_ok = 1'b1; from_mctr_data = 32'h3333_3333;
    repeat (5) begin
      tick();
      chk("stall_miss_mreq", {31'd0, to_mctr_ready}, 32'd1);
      chk("stall_miss_ok", {31'd0, to_if_ok}, 32'd0);
    end
    rdy = 1'b1; tick();
    chk("stall_resp_ok", {31'd0, to_if_ok}, 32'd1);
    chk("stall_resp_ins", to_if_ins, 32'h3333_3333);
    from_mctr_ok = 1'b0; rdy = 1'b0;
    repeat (5) begin
      tick();
      chk("stall_frozen_ok", {31'd0, to_if_ok}, 32'd1);
    end
    rdy = 1'b1; from_if_ready = 1'b0; tick();
    chk("stall_once", {31'd0, to_if_ok}, 32'd0);
    tick();
    chk("stall_once2", {31'd0, to_if_ok}, 32'd0);

    // Asynchronous reset in the middle of a miss.
    req(32'h0000_0500); tick();
    #2 rst = 1'b0;
    #1;
    chk("arst_ok", {31'd0, to_if_ok}, 32'd0);
    chk("arst_ins", to_if_ins, 32'd0);
    chk("arst_mreq", {31'd0, to_mctr_ready}, 32'd0);
    chk("arst_maddr", to_mctr_addr, 32'd0);
    from_if_ready = 1'b0; tick();
    rst = 1'b1; tick();
    do_miss("arst_cold", 32'h0000_0004, 0, mem[1]);

    // Randomized traffic against the model.
    mem_busy = 1'b0; mem_cnt = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      tick();
      last_rdy = rdy; last_clear = clear;
      if (!to_mctr_ready) begin
        from_mctr_ok = 1'b0; mem_busy = 1'b0;
      end else if (!mem_busy) begin
        mem_busy = 1'b1; mem_cnt = int'($urandom_range(0, 3)); from_mctr_ok = 1'b0;
      end else if (!from_mctr_ok && last_rdy) begin
        if (mem_cnt == 0) begin
          from_mctr_ok = 1'b1; from_mctr_data = mem[to_mctr_addr[17:2]];
        end else begin
          mem_cnt--;
        end
      end
      if ($urandom_range(0, 15) == 0) mem[$urandom_range(0, 65535) & 32'h0000_031F] = $urandom;
      if (!from_if_ready || to_if_ok || (last_clear && last_rdy)) begin
        ra = ($urandom & 32'hFFFC_0000) | ($urandom_range(0, 3) << 10)
           | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
        from_if_ready = ($urandom_range(0, 4) != 0);
        from_if_addr  = ra;
      end
      rdy   = ($urandom_range(0, 7) != 0);
      clear = ($urandom_range(0, 24) == 0);
    end
    rdy = 1'b1; clear = 1'b0; from_if_ready = 1'b0; from_mctr_ok = 1'b0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
